// File: rtl/lake_config_sequencer.sv
// Boot-time config sequencer for the LakeWrapper tile: streams a table of (addr, data)
// writes onto the config bus, optionally reads each entry back and checks it, then flushes.
module lake_config_sequencer #(
   parameter int CFG_ADDR_W = 8,
   parameter int CFG_DATA_W = 32,
   parameter int IDX_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clk_en,
   input  logic                  start,
   input  logic [IDX_W:0]        num_entries,
   input  logic                  verify_en,
   output logic [IDX_W-1:0]      tbl_idx,
   input  logic [CFG_ADDR_W-1:0] tbl_addr,
   input  logic [CFG_DATA_W-1:0] tbl_data,
   output logic                  config_en,
   output logic                  config_write,
   output logic                  config_read,
   output logic [CFG_ADDR_W-1:0] config_addr_in,
   output logic [CFG_DATA_W-1:0] config_data_in,
   input  logic [CFG_DATA_W-1:0] config_data_out_0,
   output logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [IDX_W-1:0]      err_idx
);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_VERIFY, S_DRAIN, S_FLUSH, S_DONE} state_t;

   typedef struct packed {
      logic [CFG_DATA_W-1:0] exp;
      logic [IDX_W-1:0]      idx;
   } cmp_t;

   localparam logic [IDX_W:0] MAX_N = {1'b1, {IDX_W{1'b0}}};

   state_t                state, state_nx;
   logic [IDX_W:0]        n_lat, n_clamp;
   logic                  ver_lat;
   logic                  last, accept, issue_wr, issue_rd;
   logic                  en_nx, wr_nx, rd_nx, flush_nx, done_nx;
   logic [CFG_ADDR_W-1:0] addr_nx;
   logic [CFG_DATA_W-1:0] data_nx;
   cmp_t                  cmp;
   logic                  cmp_vld;

   assign n_clamp  = (num_entries > MAX_N) ? MAX_N : num_entries;
   assign last     = ({1'b0, tbl_idx} == n_lat - 1'b1);
   // a start is also refused in the cycle the done pulse is showing
   assign accept   = (state == S_IDLE) && start && clk_en && !done;
   assign issue_wr = clk_en && (state == S_WRITE);
   assign issue_rd = clk_en && (state == S_VERIFY);
   assign busy     = (state == S_WRITE) || (state == S_VERIFY) ||
                     (state == S_DRAIN) || (state == S_FLUSH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (clk_en) begin
         case (state)
            S_IDLE:   if (accept) state_nx = (n_clamp == '0) ? S_FLUSH : S_WRITE;
            S_WRITE:  if (last) state_nx = ver_lat ? S_VERIFY : S_FLUSH;
            S_VERIFY: if (last) state_nx = S_DRAIN;
            S_DRAIN:  state_nx = S_FLUSH;
            S_FLUSH:  state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
         endcase
      end
   end

   always_comb begin
      en_nx    = issue_wr || issue_rd;
      wr_nx    = issue_wr;
      rd_nx    = issue_rd;
      addr_nx  = en_nx ? tbl_addr : '0;
      data_nx  = issue_wr ? tbl_data : '0;
      flush_nx = clk_en && (state == S_FLUSH);
      done_nx  = clk_en && (state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         config_en      <= 1'b0;
         config_write   <= 1'b0;
         config_read    <= 1'b0;
         config_addr_in <= '0;
         config_data_in <= '0;
         flush          <= 1'b0;
         done           <= 1'b0;
         tbl_idx        <= '0;
         n_lat          <= '0;
         ver_lat        <= 1'b0;
      end else begin
         config_en      <= en_nx;
         config_write   <= wr_nx;
         config_read    <= rd_nx;
         config_addr_in <= addr_nx;
         config_data_in <= data_nx;
         flush          <= flush_nx;
         done           <= done_nx;
         if (accept) begin
            n_lat   <= n_clamp;
            ver_lat <= verify_en;
            tbl_idx <= '0;
         end else if (issue_wr || issue_rd) begin
            tbl_idx <= last ? '0 : tbl_idx + 1'b1;
         end
      end
   end

   // The tile answers a read while config_read is showing, so the captured
   // expectation is checked one edge after issue, independent of clk_en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp     <= '0;
         cmp_vld <= 1'b0;
         error   <= 1'b0;
         err_idx <= '0;
      end else begin
         cmp_vld <= issue_rd;
         if (issue_rd) cmp <= '{exp: tbl_data, idx: tbl_idx};
         if (accept) begin
            error   <= 1'b0;
            err_idx <= '0;
         end else if (cmp_vld && (config_data_out_0 != cmp.exp)) begin
            error <= 1'b1;
            if (!error) err_idx <= cmp.idx;
         end
      end
   end

endmodule

// File: tb/tb_lake_config_sequencer.sv
// Directed bench for lake_config_sequencer: table model, tile readback model with
// per-address corruption, and cycle-accurate checks of strobes, flush, done and error.
module tb_lake_config_sequencer;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int IW = 4;

   logic          clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0, start = 1'b0, verify_en = 1'b0;
   logic [IW:0]   num_entries = '0;
   logic [IW-1:0] tbl_idx, err_idx;
   logic [AW-1:0] tbl_addr, config_addr_in;
   logic [DW-1:0] tbl_data, config_data_in, config_data_out_0;
   logic          config_en, config_write, config_read, flush, busy, done, error;

   logic [AW-1:0] tbl_a [16];
   logic [DW-1:0] tbl_d [16];
   logic [DW-1:0] mem   [256];
   logic          bad   [256];

   lake_config_sequencer #(.CFG_ADDR_W(AW), .CFG_DATA_W(DW), .IDX_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start),
      .num_entries(num_entries), .verify_en(verify_en), .tbl_idx(tbl_idx),
      .tbl_addr(tbl_addr), .tbl_data(tbl_data), .config_en(config_en),
      .config_write(config_write), .config_read(config_read),
      .config_addr_in(config_addr_in), .config_data_in(config_data_in),
      .config_data_out_0(config_data_out_0), .flush(flush), .busy(busy),
      .done(done), .error(error), .err_idx(err_idx)
   );

   assign tbl_addr = tbl_a[tbl_idx];
   assign tbl_data = tbl_d[tbl_idx];
   assign config_data_out_0 = config_read ?
      (mem[config_addr_in] ^ (bad[config_addr_in] ? 32'hDEAD_0000 : 32'h0)) : '0;

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int wr_cnt, rd_cnt, flush_cnt, done_cnt, flush_cyc, done_cyc, bad_strobe, busy_c1;
   int wr_cyc [32];
   int rd_cyc [32];
   logic [AW-1:0] wr_addr [32];
   logic [AW-1:0] rd_addr [32];
   logic [DW-1:0] wr_data [32];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
         $error("check %s", tag);
      end
   endtask

   function automatic logic [63:0] out_vec();
      return {9'd0, tbl_idx, config_en, config_write, config_read, config_addr_in,
              config_data_in, flush, busy, done, error, err_idx};
   endfunction

   // Entered #1 after a posedge; the next posedge is edge 0 (start accepted).
   task automatic run(input int n, input logic v, input int stall_c, input int stall_len,
                      input int again_c, input int stop_c);
      wr_cnt = 0; rd_cnt = 0; flush_cnt = 0; done_cnt = 0; bad_strobe = 0;
      flush_cyc = -1; done_cyc = -1; busy_c1 = -1;
      for (int i = 0; i < 32; i++) begin
         wr_cyc[i] = -1; rd_cyc[i] = -1; wr_addr[i] = '0; rd_addr[i] = '0; wr_data[i] = '0;
      end
      num_entries = n[IW:0]; verify_en = v; start = 1'b1; clk_en = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (config_en) begin
            if (config_write && !config_read) begin
               if (wr_cnt < 32) begin
                  wr_cyc[wr_cnt] = c; wr_addr[wr_cnt] = config_addr_in;
                  wr_data[wr_cnt] = config_data_in;
               end
               mem[config_addr_in] = config_data_in;
               wr_cnt++;
            end else if (config_read && !config_write && config_data_in == '0) begin
               if (rd_cnt < 32) begin
                  rd_cyc[rd_cnt] = c; rd_addr[rd_cnt] = config_addr_in;
               end
               rd_cnt++;
            end else bad_strobe++;
         end else if (config_write || config_read || config_addr_in != '0 || config_data_in != '0)
            bad_strobe++;
         if (c == 1) busy_c1 = busy;
         if (flush) begin flush_cnt++; flush_cyc = c; end
         if (done)  begin done_cnt++;  done_cyc  = c; end
         if (c == stop_c) break;
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
         start  = (c == again_c);
         clk_en = !(c >= stall_c && c < stall_c + stall_len);
      end
      start = 1'b0; clk_en = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin mem[i] = '0; bad[i] = 1'b0; end
      for (int i = 0; i < 16; i++) begin
         tbl_a[i] = 8'h40 + 8'(i);
         tbl_d[i] = 32'h0101_0101 * (i + 1);
      end
      tbl_a[0] = 8'h01; tbl_d[0] = 32'hA;
      tbl_a[1] = 8'h02; tbl_d[1] = 32'hB;
      tbl_a[2] = 8'h03; tbl_d[2] = 32'hC;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", out_vec(), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // plain write pass
      run(3, 1'b0, -1, 0, -1, -1);
      chk("t1_wr_cnt", wr_cnt, 3);
      chk("t1_rd_cnt", rd_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t1_wr_cyc%0d", i), wr_cyc[i], i + 1);
         chk($sformatf("t1_wr_addr%0d", i), wr_addr[i], i + 1);
         chk($sformatf("t1_wr_data%0d", i), wr_data[i], 32'hA + i);
      end
      chk("t1_busy_c1", busy_c1, 1);
      chk("t1_flush_cyc", flush_cyc, 4);
      chk("t1_done_cyc", done_cyc, 5);
      chk("t1_counts", {flush_cnt, done_cnt}, {32'd1, 32'd1});
      chk("t1_error", error, 1'b0);
      chk("t1_busy_end", busy, 1'b0);
      chk("t1_strobe_rules", bad_strobe, 0);

      // write + clean verify
      run(4, 1'b1, -1, 0, -1, -1);
      chk("t2_wr_cnt", wr_cnt, 4);
      chk("t2_rd_cnt", rd_cnt, 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_rd_addr%0d", i), rd_addr[i], tbl_a[i]);
         chk($sformatf("t2_rd_cyc%0d", i), rd_cyc[i], 5 + i);
      end
      chk("t2_flush_cyc", flush_cyc, 10);
      chk("t2_done_cyc", done_cyc, 11);
      chk("t2_error", error, 1'b0);
      chk("t2_strobe_rules", bad_strobe, 0);

      // corrupted readback on idx 2 and 3
      bad[tbl_a[2]] = 1'b1; bad[tbl_a[3]] = 1'b1;
      run(4, 1'b1, -1, 0, -1, -1);
      chk("t3_flush_cyc", flush_cyc, 10);
      chk("t3_done_cyc", done_cyc, 11);
      chk("t3_error_held", error, 1'b1);
      chk("t3_err_idx", err_idx, 2);

      // reset in the middle of the read pass
      run(4, 1'b1, -1, 0, -1, 8);
      chk("t4_error_before_rst", error, 1'b1);
      chk("t4_busy_before_rst", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk("t4_rst_outputs", out_vec(), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 256; i++) bad[i] = 1'b0;
      @(posedge clk); #1;
      run(2, 1'b0, -1, 0, -1, -1);
      chk("t4_fresh_wr_cnt", wr_cnt, 2);
      chk("t4_fresh_flush", flush_cyc, 3);
      chk("t4_fresh_done", done_cyc, 4);
      chk("t4_fresh_error", error, 1'b0);

      // two-cycle stall while idx 1 is pending
      run(3, 1'b0, 1, 2, -1, -1);
      chk("t5_wr_cnt", wr_cnt, 3);
      chk("t5_wr_cyc1", wr_cyc[1], 4);
      chk("t5_wr_cyc2", wr_cyc[2], 5);
      chk("t5_wr_addr1", wr_addr[1], tbl_a[1]);
      chk("t5_wr_addr2", wr_addr[2], tbl_a[2]);
      chk("t5_flush_cyc", flush_cyc, 6);
      chk("t5_done_cyc", done_cyc, 7);

      // empty table
      run(0, 1'b0, -1, 0, -1, -1);
      chk("t6_wr_cnt", wr_cnt + rd_cnt, 0);
      chk("t6_flush_cyc", flush_cyc, 1);
      chk("t6_done_cyc", done_cyc, 2);

      // start while busy, then start during the done pulse
      run(3, 1'b0, -1, 0, 2, -1);
      chk("t7_done_cnt", done_cnt, 1);
      chk("t7_wr_cnt", wr_cnt, 3);
      chk("t7_done_cyc", done_cyc, 5);
      run(3, 1'b0, -1, 0, 5, -1);
      chk("t7b_wr_cnt", wr_cnt, 3);
      chk("t7b_done_cnt", done_cnt, 1);
      chk("t7b_idle", busy, 1'b0);

      // oversize count clamps to the full table
      run(20, 1'b0, -1, 0, -1, -1);
      chk("t8_wr_cnt", wr_cnt, 16);
      chk("t8_last_addr", wr_addr[15], tbl_a[15]);
      chk("t8_flush_cyc", flush_cyc, 17);
      chk("t8_done_cyc", done_cyc, 18);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
